traceback_walker: RTL and testbench

TRACEBACK_WALKER -- requirements
Module: traceback_walker

---
 rtl/traceback_walker_pkg.sv | 18 +
 rtl/traceback_walker_tb_coord_step.sv | 32 +++
 rtl/traceback_walker.sv | 139 +++++++++++++
 tb/tb_traceback_walker.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traceback_walker_pkg.sv
// Direction codes and walker state encoding shared by the traceback walker,
// the scoring array and the traceback register array.
package traceback_walker_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_DIAG = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_LEFT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_TERM
    } state_t;

endpackage

// File: rtl/traceback_walker_tb_coord_step.sv
// Next traceback coordinate for one direction code, with a flag raised when the
// move would decrement an index that is already zero.
module tb_coord_step
    import traceback_walker_pkg::*;
#(
    parameter int IW = 8,
    parameter int JW = 8
) (
    input  logic [IW-1:0] row_i,
    input  logic [JW-1:0] col_i,
    input  logic [1:0]    code_i,
    output logic [IW-1:0] row_o,
    output logic [JW-1:0] col_o,
    output logic          underflow_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        row_o       = row_i;
        col_o       = col_i;
        underflow_o = 1'b0;
        if (code_i == DIR_DIAG || code_i == DIR_UP) begin
            row_o = row_i - IW'(1);
            if (row_i == '0) underflow_o = 1'b1;
        end
        if (code_i == DIR_DIAG || code_i == DIR_LEFT) begin
            col_o = col_i - JW'(1);
            if (col_i == '0) underflow_o = 1'b1;
        end
    end

endmodule

// File: rtl/traceback_walker.sv
// Walks the traceback matrix from the max-score cell, reading one direction code
// per step and streaming alignment ops, closed by a STOP terminator beat.
module traceback_walker
    import traceback_walker_pkg::*;
#(
    parameter int QLEN = 256,
    parameter int RLEN = 256,
    parameter int IW   = 8,
    parameter int JW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IW-1:0]    start_i,
    input  logic [JW-1:0]    start_j,
    output logic             rd_en,
    output logic [IW+JW-1:0] rd_addr,
    input  logic [1:0]       rd_data,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op,
    output logic             op_last,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [IW+JW:0]   op_count
);

    localparam int CW = IW + JW + 1;
    // A legal path never needs more than QLEN+RLEN moves; reaching it means a corrupt matrix.
    localparam logic [CW-1:0] OP_LIMIT = CW'(QLEN + RLEN);

    state_t          state_q, state_d;
    logic [IW-1:0]   cur_i_q, cur_i_d;
    logic [JW-1:0]   cur_j_q, cur_j_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            done_q, done_d;

    logic [IW-1:0]   nxt_i;
    logic [JW-1:0]   nxt_j;
    logic            step_uf;
    logic [CW-1:0]   count_inc;

    tb_coord_step #(.IW(IW), .JW(JW)) u_step (
        .row_i       (cur_i_q),
        .col_i       (cur_j_q),
        .code_i      (op_q),
        .row_o       (nxt_i),
        .col_o       (nxt_j),
        .underflow_o (step_uf)
    );

    assign count_inc = count_q + CW'(1);

    // NOTE: state is updated with non-blocking assignments only; every register here is a
    // plain flop, so all of them take the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_i_q   <= '0;
            cur_j_q   <= '0;
            op_q      <= DIR_STOP;
            count_q   <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_i_q   <= cur_i_d;
            cur_j_q   <= cur_j_d;
            op_q      <= op_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_i_d   = cur_i_q;
        cur_j_d   = cur_j_q;
        op_d      = op_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_i_d   = start_i;
                    cur_j_d   = start_j;
                    count_d   = '0;
                    overrun_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                op_d    = rd_data;
                state_d = (rd_data == DIR_STOP) ? S_TERM : S_EMIT;
            end
            S_EMIT: begin
                if (op_ready) begin
                    count_d = count_inc;
                    cur_i_d = nxt_i;
                    cur_j_d = nxt_j;
                    if (step_uf) begin
                        state_d = S_TERM;
                    end else if (count_inc == OP_LIMIT) begin
                        overrun_d = 1'b1;
                        state_d   = S_TERM;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_TERM: begin
                if (op_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (state_q == S_FETCH);
        rd_addr  = {cur_i_q, cur_j_q};
        op_valid = (state_q == S_EMIT) || (state_q == S_TERM);
        op       = (state_q == S_EMIT) ? op_q : DIR_STOP;
        op_last  = (state_q == S_TERM);
        busy     = (state_q != S_IDLE);
        done     = done_q;
        overrun  = overrun_q;
        op_count = count_q;
    end

endmodule

// File: tb/tb_traceback_walker.sv
// Self-checking bench for traceback_walker: a behavioural traceback memory, a
// reference walk that fills expected-beat and expected-read queues, and per-scenario tasks.
module tb_traceback_walker;

    // Index widths are wider than clog2(QLEN) so a walk can outlast QLEN+RLEN moves.
    localparam int QLEN = 4;
    localparam int RLEN = 4;
    localparam int IW   = 8;
    localparam int JW   = 8;
    localparam int AW   = IW + JW;
    localparam int CW   = AW + 1;

    localparam logic [1:0] C_STOP = 2'b00;
    localparam logic [1:0] C_DIAG = 2'b01;
    localparam logic [1:0] C_UP   = 2'b10;
    localparam logic [1:0] C_LEFT = 2'b11;

    logic          clk;
    logic          reset;
    logic          start;
    logic [IW-1:0] start_i;
    logic [JW-1:0] start_j;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op;
    logic          op_last;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [CW-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    int mode     = 0;

    logic [2:0]    exp_q[$];
    logic [2:0]    obs_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [AW-1:0] obs_rd_q[$];

    int term_cyc, done_cyc, held_err, stall_rd, stalled_cycles;
    logic busy_first;

    traceback_walker #(.QLEN(QLEN), .RLEN(RLEN), .IW(IW), .JW(JW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .start_i  (start_i),
        .start_j  (start_j),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .op_last  (op_last),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix contents per scenario.
    function automatic logic [1:0] mem_code(input int m, input int i, input int j);
        case (m)
            0: return C_DIAG;
            1: begin
                if (i == 2 && j == 2) return C_UP;
                if (i == 1 && j == 2) return C_LEFT;
                return C_STOP;
            end
            2: begin
                case ((i + j) % 3)
                    0:       return C_LEFT;
                    1:       return C_UP;
                    default: return C_DIAG;
                endcase
            end
            default: return C_STOP;
        endcase
    endfunction

    // Read data appears exactly one cycle after the strobe.
    always @(posedge clk)
        rd_data <= rd_en ? mem_code(mode, int'(rd_addr[AW-1:JW]), int'(rd_addr[JW-1:0])) : C_STOP;

    // Reference walk: expected reads and beats ({op_last, op}), op count and overrun.
    task automatic model_walk(input int si, input int sj, output int cnt, output bit ovr);
        int i = si;
        int j = sj;
        logic [1:0] c;
        bit uf;
        cnt = 0;
        ovr = 1'b0;
        for (int step = 0; step < 1000; step++) begin
            exp_rd_q.push_back(AW'(i * (1 << JW) + j));
            c = mem_code(mode, i, j);
            if (c == C_STOP) begin
                exp_q.push_back(3'b100);
                break;
            end
            exp_q.push_back({1'b0, c});
            cnt++;
            uf = 1'b0;
            if (c == C_DIAG || c == C_UP) begin
                if (i == 0) uf = 1'b1; else i--;
            end
            if (c == C_DIAG || c == C_LEFT) begin
                if (j == 0) uf = 1'b1; else j--;
            end
            if (uf) begin
                exp_q.push_back(3'b100);
                break;
            end
            if (cnt == QLEN + RLEN) begin
                ovr = 1'b1;
                exp_q.push_back(3'b100);
                break;
            end
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        exp_rd_q.delete();
        obs_rd_q.delete();
    endtask

    // Drives op_ready, records reads/beats/done at the falling edge until done or a limit.
    task automatic run_walk(input int budget, input int stall_first, input int busy_start_at,
                            input int stop_after_rd, output bit timed_out);
        int   cyc = 0;
        int   stall_left = 0;
        bit   first_seen = 1'b0;
        bit   prev_valid = 1'b0;
        bit   prev_hs = 1'b0;
        bit   hs;
        logic [2:0] prev_beat = 3'b000;
        timed_out = 1'b1;
        term_cyc = -1; done_cyc = -1; held_err = 0; stall_rd = 0; stalled_cycles = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == busy_start_at);
            if (cyc == busy_start_at) begin
                start_i = IW'(1);
                start_j = JW'(1);
            end
            if (cyc == 1) busy_first = busy;
            if (op_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = stall_first;
            end
            if (stall_left > 0) begin
                op_ready = 1'b0;
                stall_left--;
            end else begin
                op_ready = 1'b1;
            end
            if (prev_valid && !prev_hs && (!op_valid || {op_last, op} !== prev_beat)) held_err++;
            if (op_valid && !op_ready) stalled_cycles++;
            if (rd_en && op_valid) stall_rd++;
            if (rd_en) obs_rd_q.push_back(rd_addr);
            hs = op_valid && op_ready;
            if (hs) begin
                obs_q.push_back({op_last, op});
                if (op_last) term_cyc = cyc;
            end
            prev_valid = op_valid;
            prev_beat  = {op_last, op};
            prev_hs    = hs;
            if (done) begin
                done_cyc  = cyc;
                timed_out = 1'b0;
                break;
            end
            if (stop_after_rd > 0 && obs_rd_q.size() == stop_after_rd) begin
                timed_out = 1'b0;
                break;
            end
        end
        op_ready = 1'b1;
    endtask

    task automatic launch(input int si, input int sj);
        @(negedge clk);
        start   = 1'b1;
        start_i = IW'(si);
        start_j = JW'(sj);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_i = '0; start_j = '0; op_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr, op_valid, op, op_last, busy, done, overrun, op_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rd_en=%b rd_addr=%h op_valid=%b op=%b last=%b busy=%b done=%b ovr=%b cnt=%0d, want all zero",
                     rd_en, rd_addr, op_valid, op, op_last, busy, done, overrun, op_count);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy=%b rd_en=%b, want 0/0", busy, rd_en);
        end
    endtask

    task automatic test_all_diag();
        int cnt; bit ovr; bit to; logic [2:0] e, o;
        clear_queues();
        mode = 0;
        model_walk(3, 3, cnt, ovr);
        launch(3, 3);
        run_walk(200, 0, 0, 0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL diag_timeout: no done within budget"); end
        n_checks++;
        if (busy_first !== 1'b1) begin n_errors++; $display("FAIL diag_busy: got %b want 1", busy_first); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL diag_beat: got %b want %b", o, e); end
        end
        n_checks++;
        if (op_count !== CW'(cnt) || cnt != 4) begin
            n_errors++; $display("FAIL diag_count: got %0d want %0d (4)", op_count, cnt);
        end
        n_checks++;
        if (done_cyc != term_cyc + 1) begin
            n_errors++; $display("FAIL diag_done: done at %0d want %0d", done_cyc, term_cyc + 1);
        end
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_errors++; $display("FAIL diag_end_flags: busy=%b ovr=%b want 0/0", busy, overrun);
        end
    endtask

    task automatic test_up_left();
        int cnt; bit ovr; bit to; logic [2:0] e, o; logic [AW-1:0] ea, oa;
        clear_queues();
        mode = 1;
        model_walk(2, 2, cnt, ovr);
        launch(2, 2);
        run_walk(200, 0, 0, 0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL upleft_timeout: no done within budget"); end
        while (exp_rd_q.size() > 0) begin
            ea = exp_rd_q.pop_front();
            oa = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 'x;
            n_checks++;
            if (oa !== ea) begin n_errors++; $display("FAIL upleft_read: got %h want %h", oa, ea); end
        end
        n_checks++;
        if (obs_rd_q.size() != 0) begin n_errors++; $display("FAIL upleft_extra_reads: got %0d want 0", obs_rd_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL upleft_beat: got %b want %b", o, e); end
        end
        n_checks++;
        if (op_count !== CW'(cnt)) begin n_errors++; $display("FAIL upleft_count: got %0d want %0d", op_count, cnt); end
    endtask

    task automatic test_stall();
        int cnt; bit ovr; bit to; logic [2:0] e, o;
        clear_queues();
        mode = 0;
        model_walk(1, 1, cnt, ovr);
        launch(1, 1);
        run_walk(200, 5, 0, 0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL stall_timeout: no done within budget"); end
        n_checks++;
        if (stalled_cycles != 5) begin n_errors++; $display("FAIL stall_cycles: got %0d want 5", stalled_cycles); end
        n_checks++;
        if (held_err != 0) begin n_errors++; $display("FAIL stall_hold: got %0d unstable beats want 0", held_err); end
        n_checks++;
        if (stall_rd != 0) begin n_errors++; $display("FAIL stall_read: got %0d reads while op pending want 0", stall_rd); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL stall_beat: got %b want %b", o, e); end
        end
        n_checks++;
        if (op_count !== CW'(cnt)) begin n_errors++; $display("FAIL stall_count: got %0d want %0d", op_count, cnt); end
    endtask

    task automatic test_overrun();
        int cnt; bit ovr; bit to; logic [2:0] e, o;
        clear_queues();
        mode = 2;
        model_walk(20, 20, cnt, ovr);
        launch(20, 20);
        run_walk(400, 0, 0, 0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL ovr_timeout: no done within budget"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL ovr_beat: got %b want %b", o, e); end
        end
        n_checks++;
        if (overrun !== ovr || !ovr) begin n_errors++; $display("FAIL ovr_flag: got %b want %b (1)", overrun, ovr); end
        n_checks++;
        if (op_count !== CW'(cnt) || cnt != QLEN + RLEN) begin
            n_errors++; $display("FAIL ovr_count: got %0d want %0d", op_count, QLEN + RLEN);
        end
    endtask

    task automatic test_busy_start();
        int cnt; bit ovr; bit to; logic [2:0] e, o;
        clear_queues();
        mode = 0;
        model_walk(3, 3, cnt, ovr);
        launch(3, 3);
        run_walk(200, 0, 4, 0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL busy_timeout: no done within budget"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL busy_beat: got %b want %b", o, e); end
        end
        n_checks++;
        if (op_count !== CW'(cnt)) begin n_errors++; $display("FAIL busy_count: got %0d want %0d", op_count, cnt); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL busy_ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_reset_mid_walk();
        int cnt; bit ovr; bit to; logic [2:0] e, o;
        clear_queues();
        mode = 0;
        model_walk(3, 3, cnt, ovr);
        launch(3, 3);
        run_walk(200, 0, 0, 2, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL rst_second_read: second read not seen"); end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({rd_en, rd_addr, op_valid, op, op_last, busy, done, overrun, op_count} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got rd_en=%b rd_addr=%h op_valid=%b op=%b busy=%b done=%b cnt=%0d, want all zero",
                     rd_en, rd_addr, op_valid, op, busy, done, op_count);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (done || op_valid || busy) begin
                n_errors++; $display("FAIL rst_abandon: done=%b op_valid=%b busy=%b want 0/0/0", done, op_valid, busy);
            end
        end
        clear_queues();
        mode = 3;
        model_walk(0, 0, cnt, ovr);
        launch(0, 0);
        run_walk(200, 0, 0, 0, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL rst_restart_timeout: no done within budget"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL rst_restart_beat: got %b want %b", o, e); end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_errors++; $display("FAIL rst_restart_extra: got %0d extra beats want 0", obs_q.size()); end
        n_checks++;
        if (op_count !== '0) begin n_errors++; $display("FAIL rst_restart_count: got %0d want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_all_diag();
        test_up_left();
        test_stall();
        test_overrun();
        test_busy_start();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
